// File: rtl/alarm_mode_ctrl.sv
// Mode sequencer and alarm ring/snooze controller for the alarm clock.
// All outputs are registered or decoded from registered state; timers advance on tick_1hz.
module alarm_mode_ctrl #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_snooze,
    input  logic       alarm_on,
    input  logic       trigger,
    output logic       en,
    output logic       houren,
    output logic       minen,
    output logic       alhouren,
    output logic       alminen,
    output logic       updown,
    output logic       adjust,
    output logic       alarmflag,
    output logic       ringing,
    output logic       buzzer,
    output logic [2:0] state
);

    localparam logic [2:0] RUN      = 3'd0;
    localparam logic [2:0] SET_HOUR = 3'd1;
    localparam logic [2:0] SET_MIN  = 3'd2;
    localparam logic [2:0] AL_HOUR  = 3'd3;
    localparam logic [2:0] AL_MIN   = 3'd4;
    localparam logic [2:0] RING     = 3'd5;
    localparam logic [2:0] SNOOZE   = 3'd6;

    localparam int RW = (RING_SECS > 1) ? $clog2(RING_SECS) : 1;
    localparam int SW = (SNOOZE_SECS > 1) ? $clog2(SNOOZE_SECS) : 1;
    localparam int UW = $clog2(MAX_SNOOZE + 1) > 0 ? $clog2(MAX_SNOOZE + 1) : 1;

    localparam logic [RW-1:0] RING_LAST = RW'(RING_SECS - 1);
    localparam logic [SW-1:0] SNZ_LAST  = SW'(SNOOZE_SECS - 1);
    localparam logic [UW-1:0] SNZ_MAX   = UW'(MAX_SNOOZE);

    logic [RW-1:0] ring_cnt;
    logic [SW-1:0] snz_cnt;
    logic [UW-1:0] snooze_used;
    logic          trigger_q;
    logic          beep_ph;
    logic          trig_rise;
    logic          step_ok;

    assign trig_rise = trigger & ~trigger_q;
    // Exactly one of up/down is required for a step; both together cancel.
    assign step_ok   = btn_up ^ btn_down;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            trigger_q   <= 1'b0;
            ring_cnt    <= '0;
            snz_cnt     <= '0;
            snooze_used <= '0;
            beep_ph     <= 1'b0;
            updown      <= 1'b1;
            houren      <= 1'b0;
            minen       <= 1'b0;
            alhouren    <= 1'b0;
            alminen     <= 1'b0;
        end else begin
            trigger_q <= trigger;
            houren    <= 1'b0;
            minen     <= 1'b0;
            alhouren  <= 1'b0;
            alminen   <= 1'b0;

            case (state)
                RUN: begin
                    if (btn_mode) begin
                        state <= SET_HOUR;
                    end else if (trig_rise && alarm_on) begin
                        state       <= RING;
                        ring_cnt    <= '0;
                        snooze_used <= '0;
                        beep_ph     <= 1'b1;
                    end
                end
                SET_HOUR, SET_MIN, AL_HOUR, AL_MIN: begin
                    if (btn_mode) begin
                        state <= (state == AL_MIN) ? RUN : state + 3'd1;
                    end else if (step_ok) begin
                        updown   <= btn_up;
                        houren   <= (state == SET_HOUR);
                        minen    <= (state == SET_MIN);
                        alhouren <= (state == AL_HOUR);
                        alminen  <= (state == AL_MIN);
                    end
                end
                RING: begin
                    if (btn_mode || !alarm_on) begin
                        state <= RUN;
                    end else if (btn_snooze) begin
                        if (snooze_used < SNZ_MAX) begin
                            state       <= SNOOZE;
                            snooze_used <= snooze_used + UW'(1);
                            snz_cnt     <= '0;
                        end else begin
                            state <= RUN;
                        end
                    end else if (tick_1hz) begin
                        if (ring_cnt == RING_LAST) begin
                            state <= RUN;
                        end else begin
                            ring_cnt <= ring_cnt + RW'(1);
                            beep_ph  <= ~beep_ph;
                        end
                    end
                end
                SNOOZE: begin
                    if (btn_mode || !alarm_on) begin
                        state <= RUN;
                    end else if (tick_1hz) begin
                        if (snz_cnt == SNZ_LAST) begin
                            state    <= RING;
                            ring_cnt <= '0;
                            beep_ph  <= 1'b1;
                        end else begin
                            snz_cnt <= snz_cnt + SW'(1);
                        end
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign en        = !(state == SET_HOUR || state == SET_MIN);
    assign adjust    = (state >= SET_HOUR) && (state <= AL_MIN);
    assign alarmflag = (state == AL_HOUR) || (state == AL_MIN);
    assign ringing   = (state == RING);
    assign buzzer    = ringing & beep_ph;

endmodule
